// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: opcodes, flag bit indices and multiplier FSM states for alu_exec_unit
package alu_exec_pkg;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
    localparam logic [3:0] OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;
    localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11;
    localparam int FLAG_Z = 0, FLAG_V = 1, FLAG_N = 2;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: sign-magnitude shift-add multiplier, one partial-product step per cycle
module alu_iter_mul
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0] cnt;
    logic neg;
    logic [WIDTH:0] step_sum;
    // multiplier bits sit in the low half and are consumed as the partial sum shifts in from the top
    assign step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign product = neg ? -prod : prod;
    always_comb begin
        state_nx = state;
        state_nx = flush ? S_IDLE :
                   state == S_IDLE ? (start ? S_MUL : S_IDLE) :
                   state == S_MUL ? (cnt == CNT_W'(1) ? S_DONE : S_MUL) : S_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            mcand <= '0;
            prod <= '0;
            cnt <= '0;
            neg <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start && !flush) begin
                mcand <= a[WIDTH-1] ? -a : a;
                prod <= {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
                cnt <= CNT_W'(WIDTH);
                neg <= a[WIDTH-1] ^ b[WIDTH-1];
            end else if (state == S_MUL) begin
                prod <= {step_sum, prod[WIDTH-1:1]};
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered EX-stage ALU with valid/ready handshakes, iterative MUL/MULH and flag register
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LANE_W  = 4,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   input_A,
    input  logic [WIDTH-1:0]   input_B,
    input  logic [WIDTH-1:0]   imm,
    input  logic [SHAMT_W-1:0] shift_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   addr_out,
    output logic [WIDTH-1:0]   result_out,
    output logic [2:0]         flag
);
    localparam int LANES = WIDTH / LANE_W;
    localparam int HALF = WIDTH / 2;
    logic take, retire, is_mul, is_mem, mul_busy, mul_done, mul_high;
    logic z_wr, nv_wr, out_n, out_v, n_nx, v_nx, add_ovf, sub_ovf;
    logic [4:0] out_op;
    logic [2:0] flag_nx;
    logic [2*WIDTH-1:0] mul_product, ror_wide;
    logic [WIDTH-1:0] sum, diff, paddsb, red, res;
    assign in_ready = ~mul_busy & (~out_valid | out_ready);
    assign take = in_valid & in_ready & ~flush;
    assign retire = out_valid & out_ready & ~flush;
    assign is_mul = opcode == OP_MUL || opcode == OP_MULH;
    assign is_mem = opcode == {1'b0, OP_LW} || opcode == {1'b0, OP_SW};
    assign sum = input_A + input_B;
    assign diff = input_A - input_B;
    assign add_ovf = (input_A[WIDTH-1] == input_B[WIDTH-1]) && (sum[WIDTH-1] != input_A[WIDTH-1]);
    assign sub_ovf = (input_A[WIDTH-1] != input_B[WIDTH-1]) && (diff[WIDTH-1] != input_A[WIDTH-1]);
    assign n_nx = opcode[0] ? diff[WIDTH-1] : sum[WIDTH-1];
    assign v_nx = opcode[0] ? sub_ovf : add_ovf;
    assign ror_wide = {input_A, input_A} >> shift_imm;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] x, y, s;
        assign x = input_A[g*LANE_W +: LANE_W];
        assign y = input_B[g*LANE_W +: LANE_W];
        assign s = x + y;
        assign paddsb[g*LANE_W +: LANE_W] = (x[LANE_W-1] == y[LANE_W-1] && s[LANE_W-1] != x[LANE_W-1]) ?
                                            {x[LANE_W-1], {(LANE_W-1){~x[LANE_W-1]}}} : s;
    end
    always_comb begin
        red = '0;
        for (int i = 0; i < WIDTH / 8; i++)
            red = red + {{(WIDTH-8){input_A[8*i+7]}}, input_A[8*i +: 8]}
                      + {{(WIDTH-8){input_B[8*i+7]}}, input_B[8*i +: 8]};
    end
    always_comb begin
        res = '0;
        case (opcode)
            {1'b0, OP_ADD}:    res = add_ovf ? {input_A[WIDTH-1], {(WIDTH-1){~input_A[WIDTH-1]}}} : sum;
            {1'b0, OP_SUB}:    res = sub_ovf ? {input_A[WIDTH-1], {(WIDTH-1){~input_A[WIDTH-1]}}} : diff;
            {1'b0, OP_XOR}:    res = input_A ^ input_B;
            {1'b0, OP_RED}:    res = red;
            {1'b0, OP_SLL}:    res = input_A << shift_imm;
            {1'b0, OP_SRA}:    res = $signed(input_A) >>> shift_imm;
            {1'b0, OP_ROR}:    res = ror_wide[WIDTH-1:0];
            {1'b0, OP_PADDSB}: res = paddsb;
            {1'b0, OP_SW}:     res = input_B;
            {1'b0, OP_LLB}:    res = {input_A[WIDTH-1:HALF], imm[HALF-1:0]};
            {1'b0, OP_LHB}:    res = {imm[HALF-1:0], input_A[HALF-1:0]};
            default:           res = '0;
        endcase
    end
    // flags follow the result being retired, not the op being accepted in the same cycle
    assign z_wr = (out_op[4:3] == 2'b00 && out_op[3:0] != OP_RED && out_op[3:0] != OP_PADDSB) ||
                  out_op == OP_MUL || out_op == OP_MULH;
    assign nv_wr = out_op == {1'b0, OP_ADD} || out_op == {1'b0, OP_SUB};
    always_comb begin
        flag_nx = flag;
        if (z_wr) flag_nx[FLAG_Z] = ~|result_out;
        if (nv_wr) begin
            flag_nx[FLAG_N] = out_n;
            flag_nx[FLAG_V] = out_v;
        end
    end
    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst(rst), .flush(flush), .start(take & is_mul),
        .a(input_A), .b(input_B), .busy(mul_busy), .done(mul_done), .product(mul_product)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            addr_out <= '0;
            result_out <= '0;
            flag <= 3'b000;
            out_op <= '0;
            out_n <= 1'b0;
            out_v <= 1'b0;
            mul_high <= 1'b0;
        end else begin
            if (retire) flag <= flag_nx;
            if (take && is_mul) mul_high <= opcode[0];
            if (take && is_mem) addr_out <= {input_A[WIDTH-1:1], 1'b0} + {imm[WIDTH-2:0], 1'b0};
            if (flush) out_valid <= 1'b0;
            else if (mul_done) begin
                result_out <= mul_high ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
                out_op <= mul_high ? OP_MULH : OP_MUL;
                out_valid <= 1'b1;
            end else if (take && !is_mul) begin
                result_out <= res;
                out_op <= opcode;
                out_n <= n_nx;
                out_v <= v_nx;
                out_valid <= 1'b1;
            end else if (retire) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors into a scoreboard; a monitor checks results and committed flags
module tb_alu_exec_unit;
    import alu_exec_pkg::*;
    localparam int W = 16;
    logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [4:0] opcode = '0;
    logic [W-1:0] input_A = '0, input_B = '0, imm = '0, addr_out, result_out;
    logic [3:0] shift_imm = '0;
    logic [2:0] flag;
    typedef struct {
        int id;
        logic [W-1:0] res;
        logic [2:0] flg;
        bit chk;
    } exp_t;
    exp_t sbq[$];
    int tests = 0, fails = 0, next_id = 0;

    alu_exec_unit #(.WIDTH(W), .LANE_W(4), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .input_A(input_A), .input_B(input_B), .imm(imm), .shift_imm(shift_imm),
        .out_valid(out_valid), .out_ready(out_ready), .addr_out(addr_out), .result_out(result_out),
        .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] im, input logic [3:0] sh, input logic [W-1:0] er,
                         input logic [2:0] ef, input bit chk, input bit push);
        int n = 0;
        opcode = op; input_A = a; input_B = b; imm = im; shift_imm = sh; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: op %0h never accepted", op);
        end else if (push) begin
            sbq.push_back('{next_id, er, ef, chk});
            next_id++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    initial begin
        exp_t e;
        bit pend = 0;
        logic [2:0] pf = '0;
        int pid = 0;
        forever begin
            @(negedge clk);
            if (!rst) pend = 0;
            else begin
                if (pend) begin
                    check($sformatf("flag#%0d", pid), 32'(flag), 32'(pf));
                    pend = 0;
                end
                if (out_valid && out_ready && !flush) begin
                    if (sbq.size() == 0) check("unexpected_output", 32'(result_out), 32'hDEAD_BEEF);
                    else begin
                        e = sbq.pop_front();
                        if (e.chk) check($sformatf("result#%0d", e.id), 32'(result_out), 32'(e.res));
                        pf = e.flg;
                        pid = e.id;
                        pend = 1;
                    end
                end
            end
        end
    end

    initial begin
        int k, hi;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_addr", 32'(addr_out), 0);
        check("rst_result", 32'(result_out), 0);
        check("rst_flag", 32'(flag), 0);
        rst = 1;
        idle(1);
        issue({1'b0, OP_ADD},    16'h7FFF, 16'h0001, 16'h0000, 4'd0, 16'h7FFF, 3'b110, 1, 1);
        issue({1'b0, OP_SUB},    16'h0005, 16'h0005, 16'h0000, 4'd0, 16'h0000, 3'b001, 1, 1);
        issue({1'b0, OP_PADDSB}, 16'h7777, 16'h1111, 16'h0000, 4'd0, 16'h7777, 3'b001, 1, 1);
        issue({1'b0, OP_SLL},    16'h0001, 16'h0000, 16'h0000, 4'd4, 16'h0010, 3'b000, 1, 1);
        issue({1'b0, OP_SRA},    16'h8000, 16'h0000, 16'h0000, 4'd3, 16'hF000, 3'b000, 1, 1);
        issue({1'b0, OP_ROR},    16'h1234, 16'h0000, 16'h0000, 4'd4, 16'h4123, 3'b000, 1, 1);
        issue({1'b0, OP_RED},    16'h7F7F, 16'h7F7F, 16'h0000, 4'd0, 16'h01FC, 3'b000, 1, 1);
        issue({1'b0, OP_ADD},    16'hFFFF, 16'h0001, 16'h0000, 4'd0, 16'h0000, 3'b001, 1, 1);
        issue({1'b0, OP_LHB},    16'h1234, 16'h0000, 16'h00AB, 4'd0, 16'hAB34, 3'b001, 1, 1);
        issue({1'b0, OP_SUB},    16'h8000, 16'h0001, 16'h0000, 4'd0, 16'h8000, 3'b010, 1, 1);
        issue({1'b0, OP_XOR},    16'h5555, 16'h5555, 16'h0000, 4'd0, 16'h0000, 3'b011, 1, 1);
        issue({1'b0, OP_HLT},    16'h1111, 16'h2222, 16'h0000, 4'd0, 16'h0000, 3'b011, 1, 1);
        issue(5'h12,             16'h1111, 16'h2222, 16'h0000, 4'd0, 16'h0000, 3'b011, 1, 1);
        issue({1'b0, OP_SW},     16'h1000, 16'h5A5A, 16'h0003, 4'd0, 16'h5A5A, 3'b011, 1, 1);
        check("sw_addr", 32'(addr_out), 32'h1006);
        idle(3);
        // downstream stall: result must hold and the next op waits for out_ready
        out_ready = 0;
        issue({1'b0, OP_XOR}, 16'hF0F0, 16'h0FF0, 16'h0000, 4'd0, 16'hFF00, 3'b010, 1, 1);
        fork
            issue({1'b0, OP_LLB}, 16'hABCD, 16'h0000, 16'h0012, 4'd0, 16'hAB12, 3'b010, 1, 1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_result", 32'(result_out), 32'hFF00);
                    check("stall_in_ready", 32'(in_ready), 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1;
                @(negedge clk);
                check("resume_in_ready", 32'(in_ready), 1);
            end
        join
        check("addr_hold", 32'(addr_out), 32'h1006);
        idle(2);
        issue(OP_MUL, 16'hFFFD, 16'h0007, 16'h0000, 4'd0, 16'hFFEB, 3'b010, 1, 1);
        k = 0;
        hi = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            if (in_ready) hi++;
            @(posedge clk);
            #1;
            k++;
        end
        check("mul_latency", 32'(k), 17);
        check("mul_in_ready_low", 32'(hi), 0);
        issue(OP_MULH, 16'hFFFD, 16'h0007, 16'h0000, 4'd0, 16'hFFFF, 3'b010, 1, 1);
        issue(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'd0, 16'h0000, 3'b011, 1, 1);
        issue(OP_MULH, 16'h0100, 16'h0100, 16'h0000, 4'd0, 16'h0001, 3'b010, 1, 1);
        idle(25);
        issue(OP_MUL, 16'h0002, 16'h0003, 16'h0000, 4'd0, 16'h0000, 3'b000, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        flush = 1;
        idle(1);
        flush = 0;
        check("flush_in_ready", 32'(in_ready), 1);
        k = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("flush_no_output", 32'(k), 0);
        check("flush_flag", 32'(flag), 32'b010);
        opcode = {1'b0, OP_ADD}; input_A = 16'h0001; input_B = 16'h0001; in_valid = 1; flush = 1;
        idle(1);
        in_valid = 0;
        flush = 0;
        check("flush_drops_accept", 32'(out_valid), 0);
        issue(OP_MUL, 16'h0002, 16'h0003, 16'h0000, 4'd0, 16'h0000, 3'b000, 0, 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_addr", 32'(addr_out), 0);
        check("arst_result", 32'(result_out), 0);
        check("arst_flag", 32'(flag), 0);
        idle(1);
        rst = 1;
        issue({1'b0, OP_LW}, 16'h1235, 16'h0000, 16'h0002, 4'd0, 16'h0000, 3'b000, 0, 1);
        check("lw_addr", 32'(addr_out), 32'h1238);
        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        idle(3);
        check("scoreboard_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered successor to the EX-stage compute block of the 5-stage pipeline.
- Widens datapath and PADDSB lane size via parameters and adds iterative MUL/MULH (shift-add FSM, multi-cycle).
- Adds a valid/ready handshake on both sides so the pipeline can stall, plus a flush input.
- Owns the architectural Z/V/N flag register; flags commit only when a result is accepted downstream.

Parameters:
- WIDTH, 16, datapath width; multiple of 8, >= 16.
- LANE_W, 4, PADDSB saturating lane width; WIDTH % LANE_W == 0.
- SHAMT_W, 4, shift-amount width; equals $clog2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kill in-flight op and output register, same cycle.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  unit can accept a new op.
- opcode  in  5  bit4=0: base ISA 4-bit opcode; 5'h10 MUL (low half), 5'h11 MULH (signed high half).
- input_A, input_B, imm  in  WIDTH each  rs, rt, immediate.
- shift_imm  in  SHAMT_W  shift amount.
- out_valid  out  1  result registers valid.
- out_ready  in  1  downstream accepts result.
- addr_out  out  WIDTH  memory address, registered.
- result_out  out  WIDTH  ALU/store-data result, registered.
- flag  out  3  {N,V,Z} architectural flags.

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid=0, in_ready=1, addr_out=0, result_out=0, flag=3'b000; multiplier regs cleared.
- Handshakes: accept when in_valid&in_ready; retire when out_valid&out_ready. Output holds stable while out_valid&~out_ready.
- in_ready = (state==IDLE) & (~out_valid | out_ready). Back-to-back single-cycle ops give one per cycle.
- Single-cycle ops, latency 1 (result registered the cycle after accept):
  - ADD/SUB: saturating two's complement. V = overflow; N = sign of unsaturated sum.
  - XOR.
  - SLL/SRA/ROR: by shift_imm.
  - PADDSB: per-LANE_W signed saturating add.
  - RED: sum of all signed bytes of A and B, sign-extended to WIDTH.
  - LLB/LHB: replace low/high WIDTH/2 bits of A with imm[WIDTH/2-1:0].
  - SW: result = B.
  - LW/SW: addr_out = (A & ~1) + (imm<<1), wrap mod 2^WIDTH. Otherwise addr_out holds its value.
  - Undefined opcodes: result = 0, no flag write.
- MUL/MULH FSM, IDLE->MUL->DONE->IDLE:
  - On accept: latch |A|, |B| and sign; counter = WIDTH.
  - MUL state: one shift-add step per cycle; counter decrements to 0.
  - DONE: negate 2*WIDTH product if sign; load low (MUL) or high (MULH) half; out_valid=1.
  - Latency WIDTH+1 cycles from accept to out_valid; in_ready=0 throughout.
- Flag commit, on retire only:
  - Z written for all ops with opcode bit4=0 and bit3=0, except RED and PADDSB.
  - N,V written for ADD/SUB only.
  - MUL/MULH write Z only (Z = result==0).
  - No write otherwise; flags hold.
- flush: next edge clears out_valid and returns FSM to IDLE, discarding any partial product. Flags not written. Flush with a simultaneous accept drops the new op. Flush beats retire: a result offered that cycle does not commit flags.
- Retire and accept in the same cycle are both legal. The new op's result loads the output regs while the flags update from the retiring result.

Decomposition:
- Package alu_exec_pkg: opcode localparams (ADD..HLT, MUL, MULH), flag bit indices (Z=0, V=1, N=2), FSM state enum.
- Sub-module alu_iter_mul: shift-add multiplier with start/busy/done; parametrised by WIDTH.
- Remaining datapath inline.

Test Plan:
- ADD 16'h7FFF+16'h0001 -> result 16'h7FFF; after retire flag N=1, V=1, Z=0. SUB 5-5 -> 0, Z=1.
- PADDSB (LANE_W=4) A=16'h7777, B=16'h1111 -> 16'h7777 (each lane saturated). Flags unchanged.
- MUL A=-3, B=7 (WIDTH=16) -> out_valid exactly 17 cycles after accept, result 16'hFFEB. in_ready=0 during; MULH gives 16'hFFFF.
- out_ready held 0 for 5 cycles after an XOR result -> result_out stable, in_ready=0. New op accepted the cycle out_ready rises.
- flush asserted mid-MUL (cycle 8) -> out_valid never rises, in_ready=1 next cycle, flags unchanged.
- rst pulsed low asynchronously mid-MUL with out_valid=1 -> all outputs zero immediately. Next LW A=16'h1235, imm=2 -> addr_out 16'h1238.
